// File: rtl/sram_responder_if.sv
// Request/response bundle between a memory master (Core iram/dram port) and
// the sram_responder memory model.
interface sram_responder_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    sram_rd_en;
  logic [ADDR_WIDTH-1:0]   sram_rd_addr;
  logic                    sram_cancel_rd;
  logic [DATA_WIDTH-1:0]   sram_rd_data;
  logic                    sram_rd_valid;
  logic                    sram_wr_en;
  logic [ADDR_WIDTH-1:0]   sram_wr_addr;
  logic [DATA_WIDTH-1:0]   sram_wr_data;
  logic [DATA_WIDTH/8-1:0] sram_wr_mask;
  logic                    sram_wr_busy;

  modport master (
    output sram_rd_en, sram_rd_addr, sram_cancel_rd,
    output sram_wr_en, sram_wr_addr, sram_wr_data, sram_wr_mask,
    input  sram_rd_data, sram_rd_valid, sram_wr_busy
  );

  modport slave (
    input  sram_rd_en, sram_rd_addr, sram_cancel_rd,
    input  sram_wr_en, sram_wr_addr, sram_wr_data, sram_wr_mask,
    output sram_rd_data, sram_rd_valid, sram_wr_busy
  );
endinterface

// File: rtl/sram_responder.sv
// Word-addressed RAM model answering the sram_if protocol: latency-configurable reads with
// cancel, byte-masked writes with a busy window. SRAM_RESP_RAND_LAT_EN adds 0..3 random cycles.
module sram_responder #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH_LOG2 = 16,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned WR_LAT     = 1
) (
  input logic            clock,
  input logic            reset,
  sram_responder_if.slave bus
);
  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned Depth    = 1 << DEPTH_LOG2;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StRdWait = 2'd1;
  localparam logic [1:0] StWrBusy = 2'd2;

  logic [DATA_WIDTH-1:0] mem [Depth];

  logic [1:0]            state_q, state_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [DEPTH_LOG2-1:0] rd_idx, wr_idx;
  logic                  rd_fire, wr_fire;
  logic [4:0]            extra_lat, rd_lat, wr_lat;

  assign rd_idx = bus.sram_rd_addr[DEPTH_LOG2+1:2];
  assign wr_idx = bus.sram_wr_addr[DEPTH_LOG2+1:2];

  // Byte offset and bits above the word index are ignored, so addresses alias.
  logic unused_addr;
  assign unused_addr = ^{bus.sram_rd_addr[ADDR_WIDTH-1:DEPTH_LOG2+2], bus.sram_rd_addr[1:0],
                         bus.sram_wr_addr[ADDR_WIDTH-1:DEPTH_LOG2+2], bus.sram_wr_addr[1:0]};

`ifdef SRAM_RESP_RAND_LAT_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_ff @(posedge clock) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end

  assign extra_lat = {3'b000, lfsr_q[1:0]};
`else
  assign extra_lat = 5'd0;
`endif

  assign rd_lat = 5'(RD_LAT) + extra_lat;
  assign wr_lat = 5'(WR_LAT) + extra_lat;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rd_data_d = rd_data_q;
    rd_fire   = 1'b0;
    wr_fire   = 1'b0;
    if (!reset) begin
      case (state_q)
        StIdle: begin
          // A write wins over a simultaneous read; the master keeps the read held.
          if (bus.sram_wr_en) begin
            wr_fire = 1'b1;
            if (wr_lat != 5'd0) begin
              cnt_d   = wr_lat - 5'd1;
              state_d = StWrBusy;
            end
          end else if (bus.sram_rd_en) begin
            idx_d   = rd_idx;
            cnt_d   = rd_lat - 5'd1;
            state_d = StRdWait;
          end
        end
        StRdWait: begin
          if (bus.sram_cancel_rd) begin
            state_d = StIdle;
          end else if (cnt_q == 5'd0) begin
            rd_fire   = 1'b1;
            rd_data_d = mem[idx_q];
            state_d   = StIdle;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
        StWrBusy: begin
          if (cnt_q == 5'd0) state_d = StIdle;
          else               cnt_d   = cnt_q - 5'd1;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= 5'd0;
      idx_q     <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Array is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (wr_fire) begin
      for (int i = 0; i < NumBytes; i++) begin
        if (bus.sram_wr_mask[i]) mem[wr_idx][8*i +: 8] <= bus.sram_wr_data[8*i +: 8];
      end
    end
  end

  // Data is forwarded in the valid cycle and then held from the register.
  assign bus.sram_rd_valid = rd_fire;
  assign bus.sram_rd_data  = rd_data_d;
  assign bus.sram_wr_busy  = (state_q != StIdle);

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: directed protocol scenarios plus randomized
// reads/writes checked against a word-array reference model.
module tb_sram_responder;
  localparam int unsigned RdLat     = 2;
  localparam int unsigned WrLat     = 3;
  localparam int unsigned DepthLog2 = 8;
  localparam int unsigned Words     = 1 << DepthLog2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  sram_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  sram_responder #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .DEPTH_LOG2(DepthLog2),
    .RD_LAT    (RdLat),
    .WR_LAT    (WrLat)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ref_mem [Words];
  logic [31:0] ref_rd_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % Words);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] mask);
    logic [31:0] bm;
    bm = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    return (old & ~bm) | (data & bm);
  endfunction

  task automatic idle_inputs();
    bus.sram_rd_en     = 1'b0;
    bus.sram_rd_addr   = '0;
    bus.sram_cancel_rd = 1'b0;
    bus.sram_wr_en     = 1'b0;
    bus.sram_wr_addr   = '0;
    bus.sram_wr_data   = '0;
    bus.sram_wr_mask   = '0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] mask);
    @(negedge clock);
    bus.sram_wr_en = 1'b1; bus.sram_wr_addr = addr;
    bus.sram_wr_data = data; bus.sram_wr_mask = mask;
    #1 chk1("wr_idle_busy", bus.sram_wr_busy, 1'b0);
    ref_mem[widx(addr)] = merge(ref_mem[widx(addr)], data, mask);
    for (int k = 1; k <= WrLat; k++) begin
      @(negedge clock);
      bus.sram_wr_en = 1'b0;
      #1 chk1("wr_busy_high", bus.sram_wr_busy, 1'b1);
    end
    @(negedge clock);
    #1 chk1("wr_busy_clear", bus.sram_wr_busy, 1'b0);
  endtask

  task automatic do_read(input logic [31:0] addr, input string tag);
    @(negedge clock);
    bus.sram_rd_en = 1'b1; bus.sram_rd_addr = addr;
    #1 chk1("rd_accept_novalid", bus.sram_rd_valid, 1'b0);
    for (int k = 1; k < RdLat; k++) begin
      @(negedge clock);
      bus.sram_rd_en = 1'b0;
      #1 chk1("rd_wait_novalid", bus.sram_rd_valid, 1'b0);
      chk1("rd_wait_busy", bus.sram_wr_busy, 1'b1);
    end
    @(negedge clock);
    bus.sram_rd_en = 1'b0;
    #1 chk1("rd_valid_pulse", bus.sram_rd_valid, 1'b1);
    ref_rd_data = ref_mem[widx(addr)];
    chk(tag, bus.sram_rd_data, ref_rd_data);
    @(negedge clock);
    #1 chk1("rd_valid_fall", bus.sram_rd_valid, 1'b0);
    chk1("rd_done_idle", bus.sram_wr_busy, 1'b0);
  endtask

  // Write, then a read held from the following cycle (or from the same cycle when simul=1).
  task automatic wr_then_rd(input logic [31:0] waddr, input logic [31:0] wdata,
                            input logic [3:0] mask, input logic [31:0] raddr, input logic simul);
    @(negedge clock);
    bus.sram_wr_en = 1'b1; bus.sram_wr_addr = waddr;
    bus.sram_wr_data = wdata; bus.sram_wr_mask = mask;
    bus.sram_rd_en = simul; bus.sram_rd_addr = raddr;
    #1 chk1("wr_rd_idle", bus.sram_wr_busy, 1'b0);
    ref_mem[widx(waddr)] = merge(ref_mem[widx(waddr)], wdata, mask);
    for (int k = 1; k <= WrLat; k++) begin
      @(negedge clock);
      bus.sram_wr_en = 1'b0; bus.sram_rd_en = 1'b1;
      #1 chk1("wr_rd_busy", bus.sram_wr_busy, 1'b1);
      chk1("wr_rd_novalid", bus.sram_rd_valid, 1'b0);
    end
    @(negedge clock);
    #1 chk1("wr_rd_accept_idle", bus.sram_wr_busy, 1'b0);
    for (int k = 1; k < RdLat; k++) begin
      @(negedge clock);
      bus.sram_rd_en = 1'b0;
      #1 chk1("wr_rd_wait_novalid", bus.sram_rd_valid, 1'b0);
    end
    @(negedge clock);
    bus.sram_rd_en = 1'b0;
    #1 chk1("wr_rd_valid", bus.sram_rd_valid, 1'b1);
    ref_rd_data = ref_mem[widx(raddr)];
    chk("wr_rd_data", bus.sram_rd_data, ref_rd_data);
    @(negedge clock);
    #1 chk1("wr_rd_valid_fall", bus.sram_rd_valid, 1'b0);
  endtask

  // Cancel raised 'when' cycles after acceptance (RdLat = the final counter cycle).
  task automatic cancel_read(input logic [31:0] addr, input int when);
    @(negedge clock);
    bus.sram_rd_en = 1'b1; bus.sram_rd_addr = addr;
    for (int k = 1; k < when; k++) begin
      @(negedge clock);
      bus.sram_rd_en = 1'b0;
      #1 chk1("cancel_pre_novalid", bus.sram_rd_valid, 1'b0);
    end
    @(negedge clock);
    bus.sram_rd_en = 1'b0; bus.sram_cancel_rd = 1'b1;
    #1 chk1("cancel_novalid", bus.sram_rd_valid, 1'b0);
    chk("cancel_data_held", bus.sram_rd_data, ref_rd_data);
    @(negedge clock);
    bus.sram_cancel_rd = 1'b0;
    #1 chk1("cancel_busy_clear", bus.sram_wr_busy, 1'b0);
    chk1("cancel_no_late_valid", bus.sram_rd_valid, 1'b0);
    chk("cancel_data_unchanged", bus.sram_rd_data, ref_rd_data);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [3:0]  m;
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1 chk1("reset_valid", bus.sram_rd_valid, 1'b0);
    chk1("reset_busy", bus.sram_wr_busy, 1'b0);
    chk("reset_data", bus.sram_rd_data, 32'h0);
    ref_rd_data = '0;

    // Seed the low words so every later read has defined data.
    for (int i = 0; i < 16; i++) do_write(32'(i * 4), $urandom, 4'hF);

    // Read latency and data hold.
    do_write(32'h10, 32'hDEADBEEF, 4'hF);
    do_read(32'h10, "rd_deadbeef");
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      #1 chk("rd_data_hold", bus.sram_rd_data, 32'hDEADBEEF);
      chk1("rd_hold_novalid", bus.sram_rd_valid, 1'b0);
    end

    // Byte-masked write merges lanes; zero mask is a no-op; upper bits/offset alias.
    do_write(32'h4, 32'h11223344, 4'hF);
    do_write(32'h4, 32'hAABBCCDD, 4'b0101);
    do_read(32'h4, "rd_masked");
    chk("masked_const", ref_rd_data, 32'h11BB33DD);
    do_write(32'h4, 32'h99999999, 4'h0);
    do_read(32'hFFFF_F407, "rd_mask0_alias");

    // Write busy window with a held read behind it.
    wr_then_rd(32'h30, 32'h0BADF00D, 4'hF, 32'h10, 1'b0);

    // Cancel one cycle after acceptance, and in the final counter cycle.
    do_write(32'h8, 32'hCAFE0008, 4'hF);
    cancel_read(32'h8, 1);
    do_read(32'h8, "rd_after_cancel");
    cancel_read(32'h10, RdLat);
    do_read(32'h10, "rd_after_final_cancel");

    // Simultaneous read and write: write wins, read returns new data.
    wr_then_rd(32'h20, 32'h5A5A5A5A, 4'hF, 32'h20, 1'b1);

    // Back-to-back reads with rd_en held.
    @(negedge clock);
    bus.sram_rd_en = 1'b1; bus.sram_rd_addr = 32'h4;
    @(negedge clock);
    #1 chk1("b2b_busy", bus.sram_wr_busy, 1'b1);
    @(negedge clock);
    #1 chk1("b2b_valid0", bus.sram_rd_valid, 1'b1);
    chk("b2b_data0", bus.sram_rd_data, ref_mem[widx(32'h4)]);
    bus.sram_rd_addr = 32'h8;
    @(negedge clock);
    #1 chk1("b2b_idle", bus.sram_wr_busy, 1'b0);
    @(negedge clock);
    bus.sram_rd_en = 1'b0;
    #1 chk1("b2b_busy2", bus.sram_wr_busy, 1'b1);
    @(negedge clock);
    #1 chk1("b2b_valid1", bus.sram_rd_valid, 1'b1);
    ref_rd_data = ref_mem[widx(32'h8)];
    chk("b2b_data1", bus.sram_rd_data, ref_rd_data);

    // Reset while a read is pending.
    @(negedge clock);
    bus.sram_rd_en = 1'b1; bus.sram_rd_addr = 32'h20;
    @(negedge clock);
    bus.sram_rd_en = 1'b0; reset = 1'b1;
    #1 chk1("rst_cycle_novalid", bus.sram_rd_valid, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    ref_rd_data = '0;
    #1 chk1("rst_mid_valid", bus.sram_rd_valid, 1'b0);
    chk1("rst_mid_busy", bus.sram_wr_busy, 1'b0);
    chk("rst_mid_data", bus.sram_rd_data, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      #1 chk1("rst_no_late_valid", bus.sram_rd_valid, 1'b0);
    end
    do_read(32'h20, "rd_after_reset");

    // Randomized traffic over the seeded words.
    for (int n = 0; n < 40; n++) begin
      a = {$urandom_range(0, 255), 22'd0} | 32'($urandom_range(0, 15) * 4)
          | 32'($urandom_range(0, 3));
      d = $urandom;
      m = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 2))
        0:       do_write(a, d, m);
        1:       do_read(a, "rand_rd");
        default: wr_then_rd(a, d, m, 32'($urandom_range(0, 15) * 4), 1'($urandom_range(0, 1)));
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
